// File: rtl/thread_fetch_sched_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// thread_fetch_sched_pkg : shared thread-id width, fetch/redirect structs
// Rev 1.0
// ----------------------------------------------------------------------------
package thread_fetch_sched_pkg;

   localparam int TID_W = 3;
   localparam int PC_W  = 32;

   typedef struct packed {
      logic             valid;
      logic [TID_W-1:0] thread_id;
      logic [PC_W-1:0]  pc;
   } fetch_req_t;

   typedef struct packed {
      logic             empty;
      logic [TID_W-1:0] thread_id;
      logic [PC_W-1:0]  pc_n;
   } br_redirect_t;

   function automatic logic [PC_W-1:0] pc_incr(input logic [PC_W-1:0] pc);
      return pc + PC_W'(4);
   endfunction

endpackage
`default_nettype wire

// File: rtl/thread_fetch_sched_rr_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// rr_arbiter : combinational rotating-priority arbiter, search starts at last+1
// Rev 1.0
// ----------------------------------------------------------------------------
module rr_arbiter #(
   parameter int N = 8
) (
   input  logic [N-1:0]         req,
   input  logic [$clog2(N)-1:0] last,
   output logic                 gnt_valid,
   output logic [$clog2(N)-1:0] gnt_idx
);

   localparam int IW = $clog2(N);

   always_comb begin
      gnt_valid = 1'b0;
      gnt_idx   = '0;
      for (int i = 1; i <= N; i++) begin
         if (!gnt_valid && req[(int'(last) + i) % N]) begin
            gnt_valid = 1'b1;
            gnt_idx   = IW'((int'(last) + i) % N);
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/thread_fetch_sched.sv
`default_nettype none
// ----------------------------------------------------------------------------
// thread_fetch_sched : per-thread fetch PC, branch stall/redirect, RR fetch grant
// Rev 1.0
// ----------------------------------------------------------------------------
module thread_fetch_sched
   import thread_fetch_sched_pkg::*;
#(
   parameter int          NUM_THREADS = 8,
   parameter int          XLEN        = 32,
   parameter logic [31:0] RESET_PC    = 32'h0000_0000
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [NUM_THREADS-1:0] thread_en_i,
   input  logic                   br_empty_i,
   input  logic [TID_W-1:0]       br_thread_id_i,
   input  logic [XLEN-1:0]        br_pc_n_i,
   output logic                   br_pc_ack_o,
   input  logic                   dec_branch_i,
   input  logic [TID_W-1:0]       dec_thread_id_i,
   output logic                   fetch_valid_o,
   output logic [TID_W-1:0]       fetch_thread_id_o,
   output logic [XLEN-1:0]        fetch_pc_o,
   input  logic                   fetch_ready_i,
   output logic [NUM_THREADS-1:0] stalled_o
);

   logic [XLEN-1:0]        r_pc [NUM_THREADS];
   logic [NUM_THREADS-1:0] r_stalled;
   logic [TID_W-1:0]       r_rr_last;
   fetch_req_t             r_fetch;

   br_redirect_t           w_br;
   logic                   w_redir;
   logic                   w_kill;
   logic                   w_load;
   logic [NUM_THREADS-1:0] w_elig;
   logic                   w_gnt_valid;
   logic [TID_W-1:0]       w_gnt_idx;

   assign w_br    = '{empty: br_empty_i, thread_id: br_thread_id_i, pc_n: br_pc_n_i};
   assign w_redir = !w_br.empty && !rst;

   // A thread touched by a redirect or a new branch this cycle must not be
   // fetched from its stale PC.
   for (genvar t = 0; t < NUM_THREADS; t++) begin : g_elig
      assign w_elig[t] = thread_en_i[t] && !r_stalled[t]
                      && !(w_redir && (w_br.thread_id == TID_W'(t)))
                      && !(dec_branch_i && (dec_thread_id_i == TID_W'(t)));
   end

   rr_arbiter #(
      .N (NUM_THREADS)
   ) u_arb (
      .req       (w_elig),
      .last      (r_rr_last),
      .gnt_valid (w_gnt_valid),
      .gnt_idx   (w_gnt_idx)
   );

   assign w_kill = r_fetch.valid
                && ((w_redir && (w_br.thread_id == r_fetch.thread_id))
                 || (dec_branch_i && (dec_thread_id_i == r_fetch.thread_id)));
   assign w_load = (!r_fetch.valid || fetch_ready_i) && !w_kill;

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int t = 0; t < NUM_THREADS; t++) begin
            r_pc[t] <= XLEN'(RESET_PC);
         end
         r_stalled <= '0;
         r_rr_last <= TID_W'(NUM_THREADS - 1);
         r_fetch   <= '0;
      end else begin
         if (w_kill) begin
            r_fetch.valid <= 1'b0;
         end else if (w_load) begin
            r_fetch.valid <= w_gnt_valid;
            if (w_gnt_valid) begin
               r_fetch.thread_id <= w_gnt_idx;
               r_fetch.pc        <= r_pc[w_gnt_idx];
               r_pc[w_gnt_idx]   <= pc_incr(r_pc[w_gnt_idx]);
               r_rr_last         <= w_gnt_idx;
            end
         end
         if (w_redir) begin
            r_pc[w_br.thread_id]      <= w_br.pc_n;
            r_stalled[w_br.thread_id] <= 1'b0;
         end
         // Ordered after the redirect clear so a same-cycle branch keeps the stall.
         if (dec_branch_i) begin
            r_stalled[dec_thread_id_i] <= 1'b1;
         end
      end
   end

   assign br_pc_ack_o       = w_redir;
   assign fetch_valid_o     = r_fetch.valid;
   assign fetch_thread_id_o = r_fetch.thread_id;
   assign fetch_pc_o        = r_fetch.pc;
   assign stalled_o         = r_stalled;

endmodule
`default_nettype wire

// File: tb/tb_thread_fetch_sched.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_thread_fetch_sched : directed self-checking bench for thread_fetch_sched
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_thread_fetch_sched;
   import thread_fetch_sched_pkg::*;

   localparam int NT = 8;

   logic           clk = 1'b0;
   logic           rst;
   logic [NT-1:0]  thread_en_i;
   logic           br_empty_i;
   logic [TID_W-1:0] br_thread_id_i;
   logic [31:0]    br_pc_n_i;
   logic           br_pc_ack_o;
   logic           dec_branch_i;
   logic [TID_W-1:0] dec_thread_id_i;
   logic           fetch_valid_o;
   logic [TID_W-1:0] fetch_thread_id_o;
   logic [31:0]    fetch_pc_o;
   logic           fetch_ready_i;
   logic [NT-1:0]  stalled_o;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   thread_fetch_sched #(
      .NUM_THREADS (NT),
      .XLEN        (32),
      .RESET_PC    (32'h0000_0000)
   ) dut (
      .clk               (clk),
      .rst               (rst),
      .thread_en_i       (thread_en_i),
      .br_empty_i        (br_empty_i),
      .br_thread_id_i    (br_thread_id_i),
      .br_pc_n_i         (br_pc_n_i),
      .br_pc_ack_o       (br_pc_ack_o),
      .dec_branch_i      (dec_branch_i),
      .dec_thread_id_i   (dec_thread_id_i),
      .fetch_valid_o     (fetch_valid_o),
      .fetch_thread_id_o (fetch_thread_id_o),
      .fetch_pc_o        (fetch_pc_o),
      .fetch_ready_i     (fetch_ready_i),
      .stalled_o         (stalled_o)
   );

   wire [35:0] req_obs = {fetch_valid_o, fetch_thread_id_o, fetch_pc_o};

   task automatic step();
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b1; thread_en_i = '0; br_empty_i = 1'b1; br_thread_id_i = '0;
      br_pc_n_i = '0; dec_branch_i = 1'b0; dec_thread_id_i = '0; fetch_ready_i = 1'b1;
      step(); step();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      rst = 1'b1; br_empty_i = 1'b0; br_thread_id_i = 3'd3; br_pc_n_i = 32'h1234;
      #1;
      tests++; if (br_pc_ack_o !== 1'b0) begin fails++; $display("FAIL reset_ack got=%b exp=0", br_pc_ack_o); end
      step(); step();
      tests++; if (req_obs !== 36'h0) begin fails++; $display("FAIL reset_req got=%h exp=%h", req_obs, 36'h0); end
      tests++; if (stalled_o !== 8'h00) begin fails++; $display("FAIL reset_stalled got=%h exp=00", stalled_o); end
      br_empty_i = 1'b1; rst = 1'b0;
   endtask

   task automatic test_reset_mid();
      do_reset();
      thread_en_i = 8'h08; fetch_ready_i = 1'b0;
      step();
      tests++; if (req_obs !== {1'b1, 3'd3, 32'h0}) begin fails++; $display("FAIL mid_hold got=%h", req_obs); end
      rst = 1'b1; br_empty_i = 1'b0; br_thread_id_i = 3'd3; br_pc_n_i = 32'h500;
      #1;
      tests++; if (br_pc_ack_o !== 1'b0) begin fails++; $display("FAIL mid_ack got=%b exp=0", br_pc_ack_o); end
      step();
      tests++; if (fetch_valid_o !== 1'b0) begin fails++; $display("FAIL mid_drop got=%b exp=0", fetch_valid_o); end
      rst = 1'b0; br_empty_i = 1'b1; fetch_ready_i = 1'b1;
      step();
      tests++; if (req_obs !== {1'b1, 3'd3, 32'h0}) begin fails++; $display("FAIL mid_regrant got=%h exp=%h", req_obs, {1'b1, 3'd3, 32'h0}); end
   endtask

   task automatic test_round_robin();
      logic [35:0] exp;
      do_reset();
      thread_en_i = 8'hFF;
      for (int i = 0; i <= 8; i++) begin
         step();
         exp = {1'b1, 3'(i % 8), (i == 8) ? 32'h4 : 32'h0};
         tests++; if (req_obs !== exp) begin fails++; $display("FAIL rr_grant%0d got=%h exp=%h", i, req_obs, exp); end
      end
   endtask

   task automatic test_branch_redirect();
      do_reset();
      thread_en_i = 8'h04;
      step();
      tests++; if (req_obs !== {1'b1, 3'd2, 32'h0}) begin fails++; $display("FAIL br_first got=%h", req_obs); end
      dec_branch_i = 1'b1; dec_thread_id_i = 3'd2;
      step();
      dec_branch_i = 1'b0;
      tests++; if (stalled_o !== 8'h04) begin fails++; $display("FAIL br_stalled got=%h exp=04", stalled_o); end
      for (int i = 0; i < 3; i++) begin
         tests++; if (fetch_valid_o !== 1'b0) begin fails++; $display("FAIL br_nogrant%0d got=%b exp=0", i, fetch_valid_o); end
         step();
      end
      br_empty_i = 1'b0; br_thread_id_i = 3'd2; br_pc_n_i = 32'h100;
      #1;
      tests++; if (br_pc_ack_o !== 1'b1) begin fails++; $display("FAIL br_ack got=%b exp=1", br_pc_ack_o); end
      step();
      br_empty_i = 1'b1;
      tests++; if ({fetch_valid_o, stalled_o} !== 9'h000) begin fails++; $display("FAIL br_popcycle got=%h exp=000", {fetch_valid_o, stalled_o}); end
      step();
      tests++; if (req_obs !== {1'b1, 3'd2, 32'h100}) begin fails++; $display("FAIL br_pc100 got=%h", req_obs); end
      step();
      tests++; if (req_obs !== {1'b1, 3'd2, 32'h104}) begin fails++; $display("FAIL br_pc104 got=%h", req_obs); end
   endtask

   task automatic test_kill_hold();
      do_reset();
      br_empty_i = 1'b0; br_thread_id_i = 3'd3; br_pc_n_i = 32'h40;
      step();
      br_empty_i = 1'b1; thread_en_i = 8'h08; fetch_ready_i = 1'b0;
      step();
      tests++; if (req_obs !== {1'b1, 3'd3, 32'h40}) begin fails++; $display("FAIL kill_grant got=%h", req_obs); end
      step();
      tests++; if (req_obs !== {1'b1, 3'd3, 32'h40}) begin fails++; $display("FAIL kill_hold got=%h", req_obs); end
      br_empty_i = 1'b0; br_pc_n_i = 32'h200; fetch_ready_i = 1'b1;
      step();
      br_empty_i = 1'b1;
      tests++; if (fetch_valid_o !== 1'b0) begin fails++; $display("FAIL kill_drop got=%b exp=0", fetch_valid_o); end
      step();
      tests++; if (req_obs !== {1'b1, 3'd3, 32'h200}) begin fails++; $display("FAIL kill_regrant got=%h", req_obs); end
   endtask

   task automatic test_same_cycle();
      do_reset();
      br_empty_i = 1'b0; br_thread_id_i = 3'd1; br_pc_n_i = 32'h80;
      dec_branch_i = 1'b1; dec_thread_id_i = 3'd1;
      step();
      br_empty_i = 1'b1; dec_branch_i = 1'b0; thread_en_i = 8'h02;
      tests++; if (stalled_o !== 8'h02) begin fails++; $display("FAIL same_stall got=%h exp=02", stalled_o); end
      step(); step();
      tests++; if (fetch_valid_o !== 1'b0) begin fails++; $display("FAIL same_nogrant got=%b exp=0", fetch_valid_o); end
      br_empty_i = 1'b0; br_pc_n_i = 32'h90;
      step();
      br_empty_i = 1'b1;
      tests++; if (stalled_o !== 8'h00) begin fails++; $display("FAIL same_unstall got=%h exp=00", stalled_o); end
      step();
      tests++; if (req_obs !== {1'b1, 3'd1, 32'h90}) begin fails++; $display("FAIL same_resume got=%h", req_obs); end
   endtask

   task automatic test_back_to_back();
      logic [35:0] exp;
      int g;
      do_reset();
      thread_en_i = 8'h11;
      step();
      for (int k = 0; k < 8; k++) begin
         g = k / 2;
         exp = {1'b1, (g % 2 == 1) ? 3'd4 : 3'd0, 32'(4 * (g / 2))};
         tests++; if (req_obs !== exp) begin fails++; $display("FAIL b2b_%0d got=%h exp=%h", k, req_obs, exp); end
         fetch_ready_i = (k % 2 == 1);
         step();
      end
   endtask

   task automatic test_wrap();
      do_reset();
      br_empty_i = 1'b0; br_thread_id_i = 3'd5; br_pc_n_i = 32'hFFFF_FFFC;
      #1;
      tests++; if (br_pc_ack_o !== 1'b1) begin fails++; $display("FAIL wrap_ack got=%b exp=1", br_pc_ack_o); end
      step();
      br_empty_i = 1'b1; thread_en_i = 8'h20;
      #1;
      tests++; if (br_pc_ack_o !== 1'b0) begin fails++; $display("FAIL wrap_noack got=%b exp=0", br_pc_ack_o); end
      step();
      tests++; if (req_obs !== {1'b1, 3'd5, 32'hFFFF_FFFC}) begin fails++; $display("FAIL wrap_top got=%h", req_obs); end
      step();
      tests++; if (req_obs !== {1'b1, 3'd5, 32'h0}) begin fails++; $display("FAIL wrap_zero got=%h", req_obs); end
      tests++; if (br_pc_ack_o !== 1'b0) begin fails++; $display("FAIL wrap_empty_ack got=%b exp=0", br_pc_ack_o); end
   endtask

   initial begin
      rst = 1'b1; thread_en_i = '0; br_empty_i = 1'b1; br_thread_id_i = '0;
      br_pc_n_i = '0; dec_branch_i = 1'b0; dec_thread_id_i = '0; fetch_ready_i = 1'b1;
      test_reset();
      test_reset_mid();
      test_round_robin();
      test_branch_redirect();
      test_kill_hold();
      test_same_cycle();
      test_back_to_back();
      test_wrap();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/thread_fetch_sched.md
# thread_fetch_sched

Per-thread fetch scheduler and PC redirect controller for the multithreaded out-of-order core. Holds one architectural fetch PC per hardware thread and stalls a thread once the decoder reports a control-flow instruction. Drains resolved next-PCs from the branch unit's result FIFO, redirecting and un-stalling the owning thread. Grants the single fetch port round-robin among enabled, un-stalled threads.

## Interface
- `NUM_THREADS`, 8: hardware threads; thread id width `TID_W` = 3 (package constant).
- `XLEN`, 32: PC width.
- `RESET_PC`, 32'h0000_0000: reset PC of every thread.

Ports:
- `clk`  in  1: the single clock, rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `thread_en_i`  in  NUM_THREADS: per-thread enable; a disabled thread is never granted.
- `br_empty_i`  in  1: branch result FIFO empty.
- `br_thread_id_i`  in  TID_W: thread of the FIFO head entry. Show-ahead: valid whenever `br_empty_i`=0.
- `br_pc_n_i`  in  XLEN: resolved next PC of the FIFO head entry.
- `br_pc_ack_o`  out  1: pops the FIFO head (drives FIFO `rd_en`).
- `dec_branch_i`  in  1: decoder saw a branch/JAL/JALR this cycle.
- `dec_thread_id_i`  in  TID_W: thread of that instruction.
- `fetch_valid_o`  out  1: fetch request valid (registered).
- `fetch_thread_id_o`  out  TID_W: thread of the request (registered).
- `fetch_pc_o`  out  XLEN: PC to fetch (registered).
- `fetch_ready_i`  in  1: fetch stage accepts the request this cycle.
- `stalled_o`  out  NUM_THREADS: per-thread stall bits (registered).

## Operation
- Reset, with `rst` sampled high: `pc[t]`=RESET_PC, `stalled`=0, `rr_last`=NUM_THREADS-1 (thread 0 has first priority). `fetch_valid_o`=0, `fetch_thread_id_o`=0, `fetch_pc_o`=0, `stalled_o`=0. `br_pc_ack_o`=0 while `rst`=1. Reset mid-transfer drops the held request; no pops occur.
- Redirect (`redir`): `br_pc_ack_o` = !`br_empty_i` && !`rst`, so at most one entry is popped per cycle. When popped, `pc[br_thread_id_i]` <= `br_pc_n_i` and `stalled[tid]` <= 0. A redirect to an un-stalled thread is still applied.
- Stall: `dec_branch_i` sets `stalled[dec_thread_id_i]` <= 1.
  - Same cycle and same thread as a redirect: the PC takes the redirect value and the stall bit ends set. Stall wins.
- Eligibility, per cycle: `elig[t]` = `thread_en_i[t]` && !`stalled[t]` && !(redir to t this cycle) && !(dec_branch on t this cycle).
- Output register states:
  - IDLE (`fetch_valid_o`=0): load the next grant if any thread is eligible.
  - HOLD (valid, !ready): all outputs are held stable.
  - On handshake (valid && ready): load the next grant, or go to IDLE if none is eligible.
- Kill: in HOLD, a redirect or `dec_branch_i` targeting the held thread clears `fetch_valid_o` next cycle. The kill takes precedence over a same-cycle handshake; the request is not consumed.
- Grant load for thread g: `fetch_pc_o` <= `pc[g]`, `fetch_thread_id_o` <= g, `pc[g]` <= `pc[g]`+4 (modulo 2^XLEN; 32'hFFFF_FFFC wraps to 0), `rr_last` <= g.
- Arbitration is rotating priority: search starts at `rr_last`+1 mod NUM_THREADS.

## Timing
- Grant latency: selection is combinational in cycle N; `fetch_valid_o` is visible in N+1. Back-to-back grants are possible every cycle while `fetch_ready_i`=1.
- Redirect latency: pop in cycle N; the new PC is in `pc[]` in N+1; the earliest fetch of it is presented in N+2.
- Stall latency: `dec_branch_i` in N excludes that thread from selection in N; `stalled_o` is set in N+1.
- FIFO handshake: combinational `br_pc_ack_o`, one pop per non-empty cycle, never popped while empty.
- No combinational path from `fetch_ready_i` to `fetch_*` outputs. The only comb path is `br_empty_i`/`rst` to `br_pc_ack_o`.

## Structure
- Shared package (with existing constants and structs):
  - `TID_W`.
  - `fetch_req_t` {valid, thread_id, pc}.
  - `br_redirect_t` {empty, thread_id, pc_n}, matching the branch unit's FIFO output fields.
- Sub-module `rr_arbiter`: parameter N; inputs `req[N]` and `last[$clog2(N)]`; outputs `gnt_valid` and `gnt_idx`. Purely combinational, reused by the CDB arbiter.

## Test plan
- Reset, all 8 threads enabled, ready=1 -> grants in thread order 0,1,…,7,0 with PC 0 each; second grant to thread 0 has PC 4.
- Thread 2 only enabled; `dec_branch_i` tid=2 at cycle 5; FIFO pushes {tid 2, pc 32'h100} at cycle 9 -> no grant for cycles 6–9, pop at 9, `fetch_pc_o`=32'h100 at cycle 11, then 32'h104.
- Held request (ready=0) for thread 3 at PC 32'h40, redirect tid 3 to 32'h200 -> valid drops next cycle; thread 3 later granted with 32'h200.
- Same cycle: redirect tid 1 to 32'h80 and dec_branch tid 1 -> `stalled_o[1]`=1, `pc[1]`=32'h80; next redirect tid 1 to 32'h90 resumes fetch at 32'h90.
- Threads 0,4 enabled, ready toggling 1010… -> grants alternate 0,4; outputs are stable during ready=0.
- Redirect tid 5 to 32'hFFFF_FFFC, granted twice -> PCs 32'hFFFF_FFFC then 32'h0; FIFO is never popped while `br_empty_i`=1.
